// File: rtl/sbh_cg_scheduler.sv
// Sequencer for one 4x4 coefficient group through the sign-bit-hiding core:
// latch, issue in position order, await the core's result (or time out), hand off.
module sbh_cg_scheduler #(
    parameter int COEFF_W = 16,
    parameter int CG_SIZE = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cg_valid,
    output logic                       cg_ready,
    input  logic [CG_SIZE*COEFF_W-1:0] cg_coef,
    input  logic [COEFF_W-1:0]         cg_deltaU,
    input  logic [COEFF_W:0]           cg_minBound,
    input  logic [COEFF_W:0]           cg_maxBound,
    output logic                       core_valid,
    output logic [COEFF_W-1:0]         core_coef,
    output logic [3:0]                 core_pos,
    output logic                       core_load_done,
    output logic [COEFF_W-1:0]         core_deltaU,
    output logic [COEFF_W:0]           core_minBound,
    output logic [COEFF_W:0]           core_maxBound,
    input  logic                       core_valid_out,
    input  logic [COEFF_W-1:0]         core_coef_out,
    input  logic [3:0]                 core_pos_out,
    input  logic                       core_needHide,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CG_SIZE*COEFF_W-1:0] res_coef,
    output logic                       res_hidden,
    output logic                       res_timeout,
    output logic                       busy,
    output logic                       stray_seen
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    POS_LAST   = 4'(CG_SIZE - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, LOAD, WAIT, OUT} state_t;

    state_t             state;
    logic [COEFF_W-1:0] coef_buf [CG_SIZE];
    logic [COEFF_W-1:0] delta_q;
    logic [COEFF_W:0]   min_q;
    logic [COEFF_W:0]   max_q;
    logic [TW-1:0]      timer;

    assign cg_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign core_deltaU   = delta_q;
    assign core_minBound = min_q;
    assign core_maxBound = max_q;

    for (genvar g = 0; g < CG_SIZE; g++) begin : g_res
        assign res_coef[g*COEFF_W +: COEFF_W] = coef_buf[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            core_valid     <= 1'b0;
            core_coef      <= '0;
            core_pos       <= '0;
            core_load_done <= 1'b0;
            res_valid      <= 1'b0;
            res_hidden     <= 1'b0;
            res_timeout    <= 1'b0;
            stray_seen     <= 1'b0;
            timer          <= '0;
            delta_q        <= '0;
            min_q          <= '0;
            max_q          <= '0;
            for (int i = 0; i < CG_SIZE; i++) coef_buf[i] <= '0;
        end else begin
            // A result strobe is only meaningful while waiting; elsewhere just flag it.
            if (core_valid_out && state != WAIT) stray_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (cg_valid) begin
                        for (int i = 0; i < CG_SIZE; i++)
                            coef_buf[i] <= cg_coef[i*COEFF_W +: COEFF_W];
                        delta_q     <= cg_deltaU;
                        min_q       <= cg_minBound;
                        max_q       <= cg_maxBound;
                        res_hidden  <= 1'b0;
                        res_timeout <= 1'b0;
                        if (cg_coef == '0) begin
                            state     <= OUT;
                            res_valid <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            core_valid <= 1'b1;
                            core_pos   <= 4'd0;
                            core_coef  <= cg_coef[COEFF_W-1:0];
                        end
                    end
                end
                ISSUE: begin
                    if (core_pos == POS_LAST) begin
                        core_valid     <= 1'b0;
                        core_pos       <= 4'd0;
                        core_coef      <= '0;
                        core_load_done <= 1'b1;
                        state          <= LOAD;
                    end else begin
                        core_pos  <= core_pos + 4'd1;
                        core_coef <= coef_buf[core_pos + 4'd1];
                    end
                end
                LOAD: begin
                    core_load_done <= 1'b0;
                    timer          <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A core answer beats the timeout when both land together.
                    if (core_valid_out) begin
                        if (core_needHide) begin
                            coef_buf[core_pos_out] <= core_coef_out;
                            res_hidden             <= 1'b1;
                        end
                        state     <= OUT;
                        res_valid <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        res_timeout <= 1'b1;
                        state       <= OUT;
                        res_valid   <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbh_cg_scheduler.sv
// Directed bench for sbh_cg_scheduler: hiding, bypass, timeout, back-pressure,
// stray strobes, result/timeout priority and mid-issue reset.
module tb_sbh_cg_scheduler;

    localparam int COEFF_W = 16;
    localparam int CG_SIZE = 16;
    localparam int TIMEOUT = 64;
    localparam int CGW     = CG_SIZE * COEFF_W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cg_valid = 1'b0;
    logic           cg_ready;
    logic [CGW-1:0] cg_coef = '0;
    logic [15:0]    cg_deltaU = '0;
    logic [16:0]    cg_minBound = '0;
    logic [16:0]    cg_maxBound = '0;
    logic           core_valid;
    logic [15:0]    core_coef;
    logic [3:0]     core_pos;
    logic           core_load_done;
    logic [15:0]    core_deltaU;
    logic [16:0]    core_minBound;
    logic [16:0]    core_maxBound;
    logic           core_valid_out = 1'b0;
    logic [15:0]    core_coef_out = '0;
    logic [3:0]     core_pos_out = '0;
    logic           core_needHide = 1'b0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [CGW-1:0] res_coef;
    logic           res_hidden;
    logic           res_timeout;
    logic           busy;
    logic           stray_seen;

    int checks = 0;
    int errors = 0;

    logic [CGW-1:0] cgA, expA, cgB, expB, cgC, cgZero, holdCoef;

    sbh_cg_scheduler #(.COEFF_W(COEFF_W), .CG_SIZE(CG_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cg_valid(cg_valid), .cg_ready(cg_ready), .cg_coef(cg_coef),
        .cg_deltaU(cg_deltaU), .cg_minBound(cg_minBound), .cg_maxBound(cg_maxBound),
        .core_valid(core_valid), .core_coef(core_coef), .core_pos(core_pos),
        .core_load_done(core_load_done), .core_deltaU(core_deltaU),
        .core_minBound(core_minBound), .core_maxBound(core_maxBound),
        .core_valid_out(core_valid_out), .core_coef_out(core_coef_out),
        .core_pos_out(core_pos_out), .core_needHide(core_needHide),
        .res_valid(res_valid), .res_ready(res_ready), .res_coef(res_coef),
        .res_hidden(res_hidden), .res_timeout(res_timeout),
        .busy(busy), .stray_seen(stray_seen)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [CGW-1:0] actual,
                               input logic [CGW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one CG; returns #1 after the accepting edge (cycle T+1).
    task automatic applyStimulus(input logic [CGW-1:0] coef, input logic [15:0] du,
                                 input logic [16:0] mn, input logic [16:0] mx);
        @(negedge clk);
        cg_coef     = coef;
        cg_deltaU   = du;
        cg_minBound = mn;
        cg_maxBound = mx;
        cg_valid    = 1'b1;
        checkOutput("cg_ready_before_accept", cg_ready, 1);
        @(posedge clk);
        #1;
        cg_valid = 1'b0;
    endtask

    // Checks the 16 issue cycles and the load pulse; returns at T+18 (first WAIT cycle).
    task automatic runIssue(input logic [CGW-1:0] coef, input int strayAt);
        for (int i = 0; i < CG_SIZE; i++) begin
            checkOutput($sformatf("issue_valid_%0d", i), core_valid, 1);
            checkOutput($sformatf("issue_pos_%0d", i), core_pos, i);
            checkOutput($sformatf("issue_coef_%0d", i), core_coef, coef[i*COEFF_W +: COEFF_W]);
            checkOutput($sformatf("issue_ready_%0d", i), cg_ready, 0);
            if (i == strayAt) begin
                core_valid_out = 1'b1;
                core_needHide  = 1'b1;
                core_pos_out   = 4'd2;
                core_coef_out  = 16'd77;
            end
            step(1);
            core_valid_out = 1'b0;
            core_needHide  = 1'b0;
        end
        checkOutput("load_done_high", core_load_done, 1);
        checkOutput("load_valid_low", core_valid, 0);
        step(1);
        checkOutput("wait_load_done_low", core_load_done, 0);
        checkOutput("wait_busy", busy, 1);
        checkOutput("wait_res_valid_low", res_valid, 0);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        checkOutput("after_hs_cg_ready", cg_ready, 1);
        checkOutput("after_hs_res_valid", res_valid, 0);
    endtask

    initial begin
        cgZero = '0;
        cgA = '0;
        cgA[3*COEFF_W +: COEFF_W] = 16'd5;
        expA = cgA;
        expA[3*COEFF_W +: COEFF_W] = 16'd4;
        for (int i = 0; i < CG_SIZE; i++) begin
            cgB[i*COEFF_W +: COEFF_W] = 16'(i * 1000 - 7000);
            cgC[i*COEFF_W +: COEFF_W] = 16'(16'h0100 + i * 3);
        end
        expB = cgB;
        expB[15*COEFF_W +: COEFF_W] = 16'h8001;

        // Reset state
        #2;
        checkOutput("rst_cg_ready", cg_ready, 1);
        checkOutput("rst_core_valid", core_valid, 0);
        checkOutput("rst_load_done", core_load_done, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_coef", res_coef, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stray", stray_seen, 0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;

        // Hidden-sign result at T+25
        applyStimulus(cgA, 16'h1234, 17'h1ABCD, 17'h00F0F);
        checkOutput("side_deltaU", core_deltaU, 16'h1234);
        checkOutput("side_min", core_minBound, 17'h1ABCD);
        checkOutput("side_max", core_maxBound, 17'h00F0F);
        runIssue(cgA, -1);
        step(7);
        checkOutput("hide_res_valid_before", res_valid, 0);
        core_valid_out = 1'b1;
        core_needHide  = 1'b1;
        core_pos_out   = 4'd3;
        core_coef_out  = 16'd4;
        step(1);
        core_valid_out = 1'b0;
        core_needHide  = 1'b0;
        checkOutput("hide_res_valid", res_valid, 1);
        checkOutput("hide_res_coef", res_coef, expA);
        checkOutput("hide_res_hidden", res_hidden, 1);
        checkOutput("hide_res_timeout", res_timeout, 0);
        checkOutput("hide_stray", stray_seen, 0);
        handshake();

        // All-zero bypass
        applyStimulus(cgZero, 16'h0007, 17'h00001, 17'h00002);
        checkOutput("zero_res_valid", res_valid, 1);
        checkOutput("zero_core_valid", core_valid, 0);
        checkOutput("zero_res_coef", res_coef, 0);
        checkOutput("zero_res_hidden", res_hidden, 0);
        checkOutput("zero_busy", busy, 1);
        handshake();

        // Silent core: timeout at T+82, then back-pressure for 10 cycles
        applyStimulus(cgB, 16'h00AA, 17'h10000, 17'h0FFFF);
        runIssue(cgB, -1);
        step(63);
        checkOutput("to_res_valid_before", res_valid, 0);
        step(1);
        checkOutput("to_res_valid", res_valid, 1);
        checkOutput("to_res_timeout", res_timeout, 1);
        checkOutput("to_res_hidden", res_hidden, 0);
        checkOutput("to_res_coef", res_coef, cgB);
        holdCoef = cgB;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checkOutput($sformatf("hold_valid_%0d", i), res_valid, 1);
            checkOutput($sformatf("hold_coef_%0d", i), res_coef, holdCoef);
            checkOutput($sformatf("hold_hidden_%0d", i), res_hidden, 0);
            checkOutput($sformatf("hold_timeout_%0d", i), res_timeout, 1);
            checkOutput($sformatf("hold_cg_ready_%0d", i), cg_ready, 0);
        end
        handshake();

        // Stray strobe in IDLE, another in ISSUE, then result and timeout together
        core_valid_out = 1'b1;
        core_needHide  = 1'b1;
        core_pos_out   = 4'd2;
        core_coef_out  = 16'd99;
        step(1);
        core_valid_out = 1'b0;
        core_needHide  = 1'b0;
        checkOutput("stray_idle_seen", stray_seen, 1);
        checkOutput("stray_idle_ready", cg_ready, 1);
        applyStimulus(cgC, 16'h0001, 17'h00003, 17'h00004);
        runIssue(cgC, 5);
        step(63);
        checkOutput("prio_res_valid_before", res_valid, 0);
        core_valid_out = 1'b1;
        core_needHide  = 1'b0;
        step(1);
        core_valid_out = 1'b0;
        checkOutput("prio_res_valid", res_valid, 1);
        checkOutput("prio_res_timeout", res_timeout, 0);
        checkOutput("prio_res_hidden", res_hidden, 0);
        checkOutput("prio_res_coef", res_coef, cgC);
        checkOutput("prio_stray", stray_seen, 1);
        handshake();

        // Reset after core_pos=7, then a fresh CG restarts at position 0
        applyStimulus(cgA, 16'h5555, 17'h0AAAA, 17'h15555);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("pre_rst_pos_%0d", i), core_pos, i);
            if (i < 7) step(1);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cg_ready", cg_ready, 1);
        checkOutput("mid_rst_core_valid", core_valid, 0);
        checkOutput("mid_rst_core_pos", core_pos, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_stray", stray_seen, 0);
        checkOutput("mid_rst_res_coef", res_coef, 0);
        checkOutput("mid_rst_deltaU", core_deltaU, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(cgB, 16'h0F0F, 17'h00010, 17'h00020);
        runIssue(cgB, -1);
        core_valid_out = 1'b1;
        core_needHide  = 1'b1;
        core_pos_out   = 4'd15;
        core_coef_out  = 16'h8001;
        step(1);
        core_valid_out = 1'b0;
        core_needHide  = 1'b0;
        checkOutput("post_rst_res_valid", res_valid, 1);
        checkOutput("post_rst_res_coef", res_coef, expB);
        checkOutput("post_rst_hidden", res_hidden, 1);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
